// File: rtl/result_bcd_formatter.sv
// Result BCD formatter: converts a two's-complement binary result into a sign
// flag, NDIG BCD digits and a leading-zero blank mask for the display drivers.
// Conversion is sequential double-dabble, one shift step per clock.
module result_bcd_formatter #(
   parameter int WIDTH = 16,
   parameter int NDIG  = 5
) (
   input  logic                  clk,
   input  logic                  nRST,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [4*NDIG-1:0]     bcd_out,
   output logic [NDIG-1:0]       blank
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [WIDTH-1:0]      mag;
   logic [4*NDIG-1:0]     bcd_scr;
   logic [CNT_W-1:0]      cnt;
   logic                  neg_int;

   logic                  accept;
   logic                  last_step;
   logic [4*NDIG-1:0]     bcd_adj;
   logic [4*NDIG-1:0]     bcd_shift;
   logic [WIDTH-1:0]      mag_shift;

   // Magnitude of a two's-complement value; the most negative input maps to
   // 2**(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
   function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] sv;
      sv = $signed(v);
      if (sv < 0)
         mag_of = ~v + WIDTH'(1);
      else
         mag_of = v;
   endfunction

   // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
   function automatic logic [4*NDIG-1:0] dd_adjust(input logic [4*NDIG-1:0] b);
      dd_adjust = b;
      for (int i = 0; i < NDIG; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            dd_adjust[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
   endfunction

   // Digit i is blanked when it and every digit above it are zero; the ones
   // digit is always shown.
   function automatic logic [NDIG-1:0] blank_mask(input logic [4*NDIG-1:0] b);
      logic upper_zero;
      upper_zero = 1'b1;
      blank_mask = '0;
      for (int i = NDIG - 1; i >= 1; i--) begin
         upper_zero    = upper_zero && (b[4*i +: 4] == 4'd0);
         blank_mask[i] = upper_zero;
      end
   endfunction

   // A start is taken in IDLE, and also on the edge that leaves DONE so that a
   // continuously held start yields one conversion every WIDTH+1 cycles.
   assign accept    = start && ((state == IDLE) || (state == DONE));
   assign last_step = (state == CONVERT) && (cnt == CNT_W'(WIDTH - 1));
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   // One double-dabble step: adjust the digits, then shift {bcd, mag} left.
   always_comb begin
      bcd_adj   = dd_adjust(bcd_scr);
      bcd_shift = {bcd_adj[4*NDIG-2:0], mag[WIDTH-1]};
      mag_shift = {mag[WIDTH-2:0], 1'b0};
   end

   // Next-state logic for IDLE -> CONVERT -> DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONVERT;
         CONVERT: if (last_step) state_nxt = DONE;
         DONE:    state_nxt = start ? CONVERT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, scratch registers and output registers; outputs only load on the
   // final shift step so intermediate scratch values never reach the display.
   always_ff @(posedge clk) begin
      if (nRST) begin
         state   <= IDLE;
         mag     <= '0;
         bcd_scr <= '0;
         cnt     <= '0;
         neg_int <= 1'b0;
         neg     <= 1'b0;
         bcd_out <= '0;
         blank   <= {{(NDIG-1){1'b1}}, 1'b0};
      end else begin
         state <= state_nxt;
         if (accept) begin
            neg_int <= bin_in[WIDTH-1];
            mag     <= mag_of(bin_in);
            bcd_scr <= '0;
            cnt     <= '0;
         end else if (state == CONVERT) begin
            mag     <= mag_shift;
            bcd_scr <= bcd_shift;
            cnt     <= cnt + CNT_W'(1);
            if (last_step) begin
               bcd_out <= bcd_shift;
               neg     <= neg_int && (bcd_shift != '0);
               blank   <= blank_mask(bcd_shift);
            end
         end
      end
   end

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Self-checking bench for result_bcd_formatter: directed cases plus random
// values checked against a plain-arithmetic decimal reference model.
module tb_result_bcd_formatter;

   localparam int WIDTH = 16;
   localparam int NDIG  = 5;

   logic                 clk;
   logic                 nRST;
   logic                 start;
   logic [WIDTH-1:0]     bin_in;
   logic                 busy;
   logic                 done;
   logic                 neg;
   logic [4*NDIG-1:0]    bcd_out;
   logic [NDIG-1:0]      blank;

   int checks;
   int failures;

   result_bcd_formatter #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
      .clk     (clk),
      .nRST    (nRST),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .neg     (neg),
      .bcd_out (bcd_out),
      .blank   (blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: absolute value of the signed input as an integer.
   function automatic int ref_mag(input logic [WIDTH-1:0] v);
      int s;
      s = int'($signed(v));
      return (s < 0) ? -s : s;
   endfunction

   // Reference: decimal digits by repeated division.
   function automatic logic [4*NDIG-1:0] ref_bcd(input logic [WIDTH-1:0] v);
      int m;
      logic [4*NDIG-1:0] r;
      m = ref_mag(v);
      r = '0;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   // Reference: digit i (i > 0) is a leading zero iff magnitude < 10**i.
   function automatic logic [NDIG-1:0] ref_blank(input logic [WIDTH-1:0] v);
      logic [NDIG-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 1; i < NDIG; i++) begin
         p = p * 10;
         r[i] = (ref_mag(v) < p);
      end
      return r;
   endfunction

   function automatic logic ref_neg(input logic [WIDTH-1:0] v);
      return int'($signed(v)) < 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One conversion; optionally pokes a second start at loop index poke_at.
   task automatic conv(input string tag, input logic [WIDTH-1:0] v,
                       input int poke_at, input logic [WIDTH-1:0] poke_val);
      int cycles;
      logic stable;
      logic [4*NDIG+NDIG:0] prev;
      prev   = {bcd_out, neg, blank};
      stable = 1'b1;
      bin_in = v;
      start  = 1'b1;
      step();
      start  = 1'b0;
      bin_in = WIDTH'($urandom);
      cycles = 0;
      while (done !== 1'b1 && cycles < 40) begin
         if (cycles == poke_at) begin
            start  = 1'b1;
            bin_in = poke_val;
         end else begin
            start  = 1'b0;
         end
         step();
         cycles++;
         if (done !== 1'b1 && {bcd_out, neg, blank} !== prev) stable = 1'b0;
      end
      start = 1'b0;
      chk({tag, "_latency"}, 32'(cycles), 32'(WIDTH));
      chk({tag, "_stable"}, 32'(stable), 32'd1);
      chk({tag, "_bcd"}, 32'(bcd_out), 32'(ref_bcd(v)));
      chk({tag, "_neg"}, 32'(neg), 32'(ref_neg(v)));
      chk({tag, "_blank"}, 32'(blank), 32'(ref_blank(v)));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      step();
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int cycles;
      logic saw_done;
      logic [WIDTH-1:0] rv;
      checks   = 0;
      failures = 0;
      nRST     = 1'b1;
      start    = 1'b0;
      bin_in   = '0;
      step();
      step();
      nRST = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_neg", 32'(neg), 32'd0);
      chk("rst_bcd", 32'(bcd_out), 32'd0);
      chk("rst_blank", 32'(blank), 32'b11110);

      conv("zero", 16'h0000, -1, '0);
      chk("zero_blank_const", 32'(blank), 32'b11110);
      conv("p12345", 16'h3039, -1, '0);
      chk("p12345_const", 32'(bcd_out), 32'h12345);
      conv("m1", 16'hFFFF, -1, '0);
      chk("m1_const", 32'({neg, bcd_out}), 32'h100001);
      conv("min", 16'h8000, -1, '0);
      chk("min_const", 32'({neg, bcd_out}), 32'h132768);
      conv("max", 16'h7FFF, -1, '0);
      chk("max_const", 32'({neg, bcd_out}), 32'h032767);
      conv("ignore", 16'h0064, 4, 16'h0001);
      chk("ignore_const", 32'({bcd_out, blank}), {12'h0, 20'h00100} << 5 | 32'b11000);

      // Reset in the middle of a conversion: no done, outputs back to reset.
      conv("pre_rst", 16'hFF85, -1, '0);
      bin_in = 16'h1234;
      start  = 1'b1;
      step();
      start = 1'b0;
      repeat (7) step();
      nRST = 1'b1;
      step();
      nRST = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_neg", 32'(neg), 32'd0);
      chk("mrst_bcd", 32'(bcd_out), 32'd0);
      chk("mrst_blank", 32'(blank), 32'b11110);
      saw_done = 1'b0;
      repeat (20) begin
         step();
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk("mrst_nodone", 32'(saw_done), 32'd0);
      conv("after_rst", 16'h00FF, -1, '0);
      chk("after_rst_const", 32'(bcd_out), 32'h00255);

      // Held start: back-to-back conversions, one every WIDTH+1 cycles.
      bin_in = 16'hD8F1;
      start  = 1'b1;
      step();
      cycles = 0;
      while (done !== 1'b1 && cycles < 40) begin
         step();
         cycles++;
      end
      chk("b2b_first_lat", 32'(cycles), 32'(WIDTH));
      chk("b2b_first_bcd", 32'(bcd_out), 32'(ref_bcd(16'hD8F1)));
      bin_in = 16'h0309;
      cycles = 0;
      do begin
         step();
         cycles++;
         if (cycles == 1) bin_in = 16'hAAAA;
      end while (done !== 1'b1 && cycles < 40);
      start = 1'b0;
      chk("b2b_period", 32'(cycles), 32'(WIDTH + 1));
      chk("b2b_second_bcd", 32'(bcd_out), 32'(ref_bcd(16'h0309)));
      chk("b2b_second_neg", 32'(neg), 32'd0);
      step();
      chk("b2b_end", 32'(done), 32'd0);

      // Random values, some with an ignored start poked mid-conversion.
      for (int n = 0; n < 12; n++) begin
         rv = WIDTH'($urandom);
         if (n % 4 == 1) rv = WIDTH'($urandom_range(0, 99));
         if (n % 4 == 3) rv = WIDTH'(-int'($urandom_range(0, 999)));
         conv("rand", rv, (n % 2 == 0) ? int'($urandom_range(0, 14)) : -1,
              WIDTH'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Overall time bound so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
